vending_controller: RTL and testbench
=====================================

Name: vending_controller

Overview:
- Sequencing controller for the two-product vending datapath (product A = 10 units, product B = 15 units; coins of 5 and 10 units).
- Accumulates credit up to a cap and arbitrates between coin insertion, product selection and cancel.
- Tracks per-product stock.
- Pays change or refunds one 5-unit coin at a time through a req/ack handshake with the coin hopper.
- Sits between the coin/keypad front end and the dispenser/hopper actuators.

Parameters:
PRICE_A, 10, cost of product A (multiple of 5)
PRICE_B, 15, cost of product B (multiple of 5)
MAX_CREDIT, 30, highest credit held; must be ≥ PRICE_B, multiple of 5
CW, 6, credit register width; must hold MAX_CREDIT
STOCK_INIT, 4, stock loaded per product at reset/refill
SW, 4, stock counter width
TIMEOUT_CYCLES, 1000, inactivity limit (optional feature only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
coin  in  2  00 none, 01 five units, 10 ten units, 11 invalid
select  in  2  00 none, 01 product A, 10 product B, 11 cancel/refund
refill  in  1  reload both stocks to STOCK_INIT
chg_ack  in  1  hopper has ejected one 5-unit coin
dispense_A  out  1  one-cycle pulse, vend A
dispense_B  out  1  one-cycle pulse, vend B
chg_req  out  1  request one 5-unit coin from hopper
reject  out  1  one-cycle pulse, coin returned unaccepted
credit  out  CW  current credit, in units
busy  out  1  high in VEND or PAYOUT
sold_out_A  out  1  stock_A == 0
sold_out_B  out  1  stock_B == 0

Behaviour:
- Registered outputs. Inputs are sampled at edge N; any response appears in the cycle after edge N.
- Reset values:
  - state IDLE; credit 0; stock_A = stock_B = STOCK_INIT.
  - all pulses and chg_req 0; busy 0.
  - sold_out_* reflect stock (0 when STOCK_INIT > 0).
- States: IDLE (credit == 0), CREDIT (0 < credit), VEND, PAYOUT.
- Coin handling, IDLE/CREDIT:
  - valid coin (01/10): credit += value, state → CREDIT.
  - if credit + value > MAX_CREDIT: reject pulse, credit unchanged.
  - coin 11: reject pulse, always.
- Coins arriving in VEND or PAYOUT: reject pulse, no credit change.
- Coin and select in the same cycle: the coin is processed and the select is ignored.
- Select A/B in CREDIT:
  - Vend only if credit ≥ price and stock > 0. Otherwise ignore silently: no pulse, state held.
  - On vend: go to VEND; next cycle dispense_X = 1 for exactly one cycle, credit -= price, stock_X -= 1.
  - VEND lasts one cycle, then goes to PAYOUT if credit > 0, else IDLE.
- Select A/B in IDLE: ignored.
- Cancel (11):
  - in CREDIT → PAYOUT (full refund).
  - in IDLE, VEND or PAYOUT: ignored.
- PAYOUT:
  - chg_req held high until sampled with chg_ack = 1. That handshake cycle gives credit -= 5.
  - If resulting credit == 0: chg_req drops, state → IDLE. Otherwise chg_req stays high for the next coin.
  - chg_ack while chg_req = 0 is ignored.
- Refill:
  - honoured only in IDLE: both stocks set to STOCK_INIT; never exceeds STOCK_INIT.
  - ignored in other states.
- Stock decrements saturate at 0; sold_out_X updates the same cycle as the stock register.
- Reset mid-VEND or mid-PAYOUT: aborts immediately; credit lost; chg_req low from the next cycle.
- credit is never negative, never exceeds MAX_CREDIT, and is always a multiple of 5.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- Defined:
  - Counter (clog2(TIMEOUT_CYCLES+1) bits) runs only in CREDIT.
  - Cleared on any valid coin or select; cleared on leaving CREDIT.
  - Reaching TIMEOUT_CYCLES forces CREDIT → PAYOUT (auto-refund) on the next edge.
- Undefined: no counter; credit is held in CREDIT indefinitely.

Decomposition:
- Package vend_pkg:
  - coin encodings (COIN_NONE/5/10/BAD) and select encodings (SEL_NONE/A/B/CANCEL).
  - state enum (ST_IDLE, ST_CREDIT, ST_VEND, ST_PAYOUT).
  - COIN_UNIT = 5 and coin value constants.
- Sub-module vend_stock_counter, instantiated twice:
  - load (refill/reset), saturating decrement, sold_out flag.
  - parameterised by SW and STOCK_INIT.

Test Plan:
- Coin 10, then select A: dispense_A pulse 1 cycle, credit 10 → 0, no chg_req, stock_A 4 → 3, back to IDLE.
- Coins 10, 10, then select B: dispense_B pulse, credit 20 → 5, chg_req high. ack after 3 cycles: credit 0, chg_req low, IDLE.
- Coins 10, 10, 10 (credit 30), then coin 5: reject pulse, credit stays 30. Cancel: 6 payout handshakes, credit reaches 0.
- Credit 5, select A: no dispense, credit 5, state CREDIT. Coin 10 and select B in the same cycle: credit 15, no dispense.
- Vend A four times from STOCK_INIT = 4: sold_out_A = 1, fifth select A ignored. refill in IDLE: stock_A = 4, sold_out_A = 0.
- Reset asserted during PAYOUT with credit 10: next cycle credit 0, chg_req 0, IDLE. With VEND_TIMEOUT_EN and TIMEOUT_CYCLES = 20: coin 5 then idle 20 cycles → PAYOUT, one handshake, IDLE.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared encodings, coin values and FSM state type for the vending controller slice.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    localparam logic [1:0] SEL_NONE   = 2'b00;
    localparam logic [1:0] SEL_A      = 2'b01;
    localparam logic [1:0] SEL_B      = 2'b10;
    localparam logic [1:0] SEL_CANCEL = 2'b11;

    localparam int COIN_UNIT    = 5;
    localparam int COIN5_VALUE  = 5;
    localparam int COIN10_VALUE = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_VEND,
        ST_PAYOUT
    } state_e;

    // Face value of an accepted coin; anything other than a 10 is treated as a 5.
    function automatic int coin_value(input logic [1:0] code);
        return (code == COIN_10) ? COIN10_VALUE : COIN5_VALUE;
    endfunction

endpackage

// File: rtl/vend_stock_counter.sv
// Per-product stock counter: reload on reset/refill, saturating decrement, registered sold-out flag.
module vend_stock_counter #(
    parameter int SW         = 4,
    parameter int STOCK_INIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          dec_i,
    output logic [SW-1:0] count_o,
    output logic          sold_out_o
);

    logic [SW-1:0] count_q;
    logic          soldOut_q;

    // The flag is registered next to the count so both change on the same edge.
    always_ff @(posedge clk) begin
        if (reset || load_i) begin
            count_q   <= SW'(STOCK_INIT);
            soldOut_q <= (STOCK_INIT == 0);
        end else if (dec_i && (count_q != '0)) begin
            count_q   <= count_q - SW'(1);
            soldOut_q <= (count_q == SW'(1));
        end
    end

    assign count_o    = count_q;
    assign sold_out_o = soldOut_q;

endmodule

// File: rtl/vending_controller.sv
// Vending sequencer: credit accumulation, product vend, change/refund payout and stock tracking.
// Optional inactivity auto-refund is compiled in with `define VEND_TIMEOUT_EN.
module vending_controller
    import vend_pkg::*;
#(
    parameter int PRICE_A    = 10,
    parameter int PRICE_B    = 15,
    parameter int MAX_CREDIT = 30,
    parameter int CW         = 6,
    parameter int STOCK_INIT = 4,
    parameter int SW         = 4
`ifdef VEND_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    coin,
    input  logic [1:0]    select,
    input  logic          refill,
    input  logic          chg_ack,
    output logic          dispense_A,
    output logic          dispense_B,
    output logic          chg_req,
    output logic          reject,
    output logic [CW-1:0] credit,
    output logic          busy,
    output logic          sold_out_A,
    output logic          sold_out_B
);

    localparam logic [CW-1:0] PRICE_A_C   = CW'(PRICE_A);
    localparam logic [CW-1:0] PRICE_B_C   = CW'(PRICE_B);
    localparam logic [CW-1:0] COIN_UNIT_C = CW'(COIN_UNIT);
    localparam logic [CW:0]   MAX_CREDIT_C = (CW+1)'(MAX_CREDIT);

    state_e        state_q;
    logic [CW-1:0] credit_q;
    logic          vendB_q;
    logic          dispA_q;
    logic          dispB_q;
    logic          chgReq_q;
    logic          reject_q;
    logic          busy_q;

    logic [SW-1:0] stockA;
    logic [SW-1:0] stockB;
    logic          soldOutA;
    logic          soldOutB;

    logic          coinValid;
    logic [CW-1:0] coinValue;
    logic [CW:0]   creditSum;
    logic          coinFits;
    logic          canVendA;
    logic          canVendB;
    logic [CW-1:0] vendPrice;
    logic          stockLoad;
    logic          decA;
    logic          decB;
    logic          timeoutHit;

    // One bit of headroom on the sum keeps the cap check honest near 2**CW.
    always_comb begin
        coinValid = (coin == COIN_5) || (coin == COIN_10);
        coinValue = CW'(coin_value(coin));
        creditSum = {1'b0, credit_q} + {1'b0, coinValue};
        coinFits  = (creditSum <= MAX_CREDIT_C);
        canVendA  = (credit_q >= PRICE_A_C) && (stockA != '0);
        canVendB  = (credit_q >= PRICE_B_C) && (stockB != '0);
        vendPrice = vendB_q ? PRICE_B_C : PRICE_A_C;
        stockLoad = refill && (state_q == ST_IDLE);
        decA      = (state_q == ST_VEND) && !vendB_q;
        decB      = (state_q == ST_VEND) && vendB_q;
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idleCnt_q;

    // Counts quiet cycles in CREDIT; any valid coin, any select, or leaving CREDIT restarts it.
    always_ff @(posedge clk) begin
        if (reset || (state_q != ST_CREDIT) || coinValid || (select != SEL_NONE)) begin
            idleCnt_q <= '0;
        end else if (idleCnt_q != TW'(TIMEOUT_CYCLES)) begin
            idleCnt_q <= idleCnt_q + TW'(1);
        end
    end

    assign timeoutHit = (state_q == ST_CREDIT) && (idleCnt_q == TW'(TIMEOUT_CYCLES));
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            vendB_q  <= 1'b0;
            dispA_q  <= 1'b0;
            dispB_q  <= 1'b0;
            chgReq_q <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            dispA_q  <= 1'b0;
            dispB_q  <= 1'b0;
            reject_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_CREDIT: begin
                    // Any coin activity wins over a select presented in the same cycle.
                    if (coin == COIN_BAD) begin
                        reject_q <= 1'b1;
                    end else if (coinValid) begin
                        if (coinFits) begin
                            credit_q <= creditSum[CW-1:0];
                            state_q  <= ST_CREDIT;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end else if (state_q == ST_CREDIT) begin
                        if ((select == SEL_A) && canVendA) begin
                            vendB_q <= 1'b0;
                            state_q <= ST_VEND;
                            busy_q  <= 1'b1;
                        end else if ((select == SEL_B) && canVendB) begin
                            vendB_q <= 1'b1;
                            state_q <= ST_VEND;
                            busy_q  <= 1'b1;
                        end else if (select == SEL_CANCEL) begin
                            state_q  <= ST_PAYOUT;
                            chgReq_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end else if ((select == SEL_NONE) && timeoutHit) begin
                            state_q  <= ST_PAYOUT;
                            chgReq_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                end
                ST_VEND: begin
                    reject_q <= (coin != COIN_NONE);
                    dispA_q  <= !vendB_q;
                    dispB_q  <= vendB_q;
                    credit_q <= credit_q - vendPrice;
                    if (credit_q == vendPrice) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q  <= ST_PAYOUT;
                        chgReq_q <= 1'b1;
                    end
                end
                ST_PAYOUT: begin
                    reject_q <= (coin != COIN_NONE);
                    if (chgReq_q && chg_ack) begin
                        credit_q <= credit_q - COIN_UNIT_C;
                        if (credit_q == COIN_UNIT_C) begin
                            chgReq_q <= 1'b0;
                            state_q  <= ST_IDLE;
                            busy_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    vend_stock_counter #(
        .SW         (SW),
        .STOCK_INIT (STOCK_INIT)
    ) u_stock_a (
        .clk        (clk),
        .reset      (reset),
        .load_i     (stockLoad),
        .dec_i      (decA),
        .count_o    (stockA),
        .sold_out_o (soldOutA)
    );

    vend_stock_counter #(
        .SW         (SW),
        .STOCK_INIT (STOCK_INIT)
    ) u_stock_b (
        .clk        (clk),
        .reset      (reset),
        .load_i     (stockLoad),
        .dec_i      (decB),
        .count_o    (stockB),
        .sold_out_o (soldOutB)
    );

    assign dispense_A = dispA_q;
    assign dispense_B = dispB_q;
    assign chg_req    = chgReq_q;
    assign reject     = reject_q;
    assign credit     = credit_q;
    assign busy       = busy_q;
    assign sold_out_A = soldOutA;
    assign sold_out_B = soldOutB;

endmodule

// File: tb/tb_vending_controller.sv
// Bench for vending_controller: pulse scoreboard plus per-scenario state checks.
// Covers the VEND_TIMEOUT_EN auto-refund path when that macro is defined.
module tb_vending_controller;
    import vend_pkg::*;

    localparam int CW     = 6;
    localparam int EV_A   = 1;
    localparam int EV_B   = 2;
    localparam int EV_REJ = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    coin = COIN_NONE;
    logic [1:0]    select = SEL_NONE;
    logic          refill = 1'b0;
    logic          chg_ack = 1'b0;
    logic          dispense_A;
    logic          dispense_B;
    logic          chg_req;
    logic          reject;
    logic [CW-1:0] credit;
    logic          busy;
    logic          sold_out_A;
    logic          sold_out_B;

    int checks = 0;
    int failures = 0;
    int expQ[$];
    int monEv;
    logic [2:0] seen;

    vending_controller #(
        .PRICE_A    (10),
        .PRICE_B    (15),
        .MAX_CREDIT (30),
        .CW         (CW),
        .STOCK_INIT (4),
        .SW         (4)
`ifdef VEND_TIMEOUT_EN
        , .TIMEOUT_CYCLES (20)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .coin       (coin),
        .select     (select),
        .refill     (refill),
        .chg_ack    (chg_ack),
        .dispense_A (dispense_A),
        .dispense_B (dispense_B),
        .chg_req    (chg_req),
        .reject     (reject),
        .credit     (credit),
        .busy       (busy),
        .sold_out_A (sold_out_A),
        .sold_out_B (sold_out_B)
    );

    always #5 clk = ~clk;

    // Every observed pulse must match the oldest expected event, in A, B, reject order.
    always @(negedge clk) begin
        seen = {reject === 1'b1, dispense_B === 1'b1, dispense_A === 1'b1};
        for (int k = 0; k < 3; k++) begin
            if (seen[k]) begin
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL pulse_unexpected: got event %0d, expected no pulse", k + 1);
                end else begin
                    monEv = expQ.pop_front();
                    if (monEv != k + 1) begin
                        failures++;
                        $display("[TB] FAIL pulse_order: got event %0d, expected event %0d", k + 1, monEv);
                    end
                end
            end
        end
    end

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] c, input logic [1:0] s,
                                 input logic r, input logic a);
        coin = c;
        select = s;
        refill = r;
        chg_ack = a;
        cycle();
        coin = COIN_NONE;
        select = SEL_NONE;
        refill = 1'b0;
        chg_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        checks++; if (credit !== 6'd0) begin failures++; $display("[TB] FAIL reset_credit: got %0d, expected 0", credit); end
        checks++; if (chg_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_chg_req: got %b, expected 0", chg_req); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if ({sold_out_A, sold_out_B} !== 2'b00) begin failures++; $display("[TB] FAIL reset_sold_out: got %b, expected 00", {sold_out_A, sold_out_B}); end
        checks++; if ({dispense_A, dispense_B, reject} !== 3'b000) begin failures++; $display("[TB] FAIL reset_pulses: got %b, expected 000", {dispense_A, dispense_B, reject}); end
    endtask

    task automatic test_vend_exact();
        applyStimulus(COIN_10, SEL_NONE, 1'b0, 1'b0);
        checks++; if (credit !== 6'd10) begin failures++; $display("[TB] FAIL exact_credit_in: got %0d, expected 10", credit); end
        expQ.push_back(EV_A);
        applyStimulus(COIN_NONE, SEL_A, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL exact_busy_vend: got %b, expected 1", busy); end
        applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b0);
        checks++; if (credit !== 6'd0) begin failures++; $display("[TB] FAIL exact_credit_out: got %0d, expected 0", credit); end
        checks++; if ({chg_req, busy} !== 2'b00) begin failures++; $display("[TB] FAIL exact_idle: got chg_req/busy %b, expected 00", {chg_req, busy}); end
        applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b0);
        checks++; if (expQ.size() !== 0) begin failures++; $display("[TB] FAIL exact_pending: got %0d pending, expected 0", expQ.size()); end
    endtask

    task automatic test_change();
        applyStimulus(COIN_10, SEL_NONE, 1'b0, 1'b0);
        applyStimulus(COIN_10, SEL_NONE, 1'b0, 1'b0);
        expQ.push_back(EV_B);
        applyStimulus(COIN_NONE, SEL_B, 1'b0, 1'b0);
        applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b0);
        checks++; if (credit !== 6'd5) begin failures++; $display("[TB] FAIL change_credit: got %0d, expected 5", credit); end
        checks++; if (chg_req !== 1'b1) begin failures++; $display("[TB] FAIL change_req: got %b, expected 1", chg_req); end
        for (int i = 0; i < 3; i++) applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b0);
        checks++; if ({chg_req, credit} !== {1'b1, 6'd5}) begin failures++; $display("[TB] FAIL change_hold: got req %b credit %0d, expected req 1 credit 5", chg_req, credit); end
        applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b1);
        checks++; if ({chg_req, busy, credit} !== {2'b00, 6'd0}) begin failures++; $display("[TB] FAIL change_done: got req %b busy %b credit %0d, expected 0 0 0", chg_req, busy, credit); end
        applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b1);
        checks++; if ({chg_req, credit} !== {1'b0, 6'd0}) begin failures++; $display("[TB] FAIL change_stray_ack: got req %b credit %0d, expected 0 0", chg_req, credit); end
        checks++; if (expQ.size() !== 0) begin failures++; $display("[TB] FAIL change_pending: got %0d pending, expected 0", expQ.size()); end
    endtask

    task automatic test_cap_and_cancel();
        for (int i = 0; i < 3; i++) applyStimulus(COIN_10, SEL_NONE, 1'b0, 1'b0);
        checks++; if (credit !== 6'd30) begin failures++; $display("[TB] FAIL cap_credit: got %0d, expected 30", credit); end
        expQ.push_back(EV_REJ);
        applyStimulus(COIN_5, SEL_NONE, 1'b0, 1'b0);
        checks++; if (credit !== 6'd30) begin failures++; $display("[TB] FAIL cap_over: got %0d, expected 30", credit); end
        expQ.push_back(EV_REJ);
        applyStimulus(COIN_BAD, SEL_NONE, 1'b0, 1'b0);
        applyStimulus(COIN_NONE, SEL_CANCEL, 1'b0, 1'b0);
        checks++; if ({busy, chg_req} !== 2'b11) begin failures++; $display("[TB] FAIL cancel_payout: got busy/req %b, expected 11", {busy, chg_req}); end
        expQ.push_back(EV_REJ);
        applyStimulus(COIN_10, SEL_A, 1'b0, 1'b0);
        checks++; if (credit !== 6'd30) begin failures++; $display("[TB] FAIL payout_coin: got %0d, expected 30", credit); end
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b1);
            checks++;
            if (credit !== 6'(30 - 5 * i)) begin
                failures++;
                $display("[TB] FAIL refund_step%0d: got %0d, expected %0d", i, credit, 30 - 5 * i);
            end
        end
        checks++; if ({chg_req, busy} !== 2'b00) begin failures++; $display("[TB] FAIL refund_end: got req/busy %b, expected 00", {chg_req, busy}); end
        checks++; if (expQ.size() !== 0) begin failures++; $display("[TB] FAIL cancel_pending: got %0d pending, expected 0", expQ.size()); end
    endtask

    task automatic test_insufficient();
        applyStimulus(COIN_5, SEL_NONE, 1'b0, 1'b0);
        applyStimulus(COIN_NONE, SEL_A, 1'b0, 1'b0);
        applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b0);
        checks++; if ({busy, credit} !== {1'b0, 6'd5}) begin failures++; $display("[TB] FAIL short_credit: got busy %b credit %0d, expected 0 5", busy, credit); end
        applyStimulus(COIN_10, SEL_B, 1'b0, 1'b0);
        applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b0);
        checks++; if ({busy, credit} !== {1'b0, 6'd15}) begin failures++; $display("[TB] FAIL coin_wins: got busy %b credit %0d, expected 0 15", busy, credit); end
        applyStimulus(COIN_NONE, SEL_CANCEL, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b1);
        checks++; if ({busy, chg_req, credit} !== {2'b00, 6'd0}) begin failures++; $display("[TB] FAIL short_refund: got busy %b req %b credit %0d, expected 0 0 0", busy, chg_req, credit); end
    endtask

    task automatic test_stock();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(COIN_10, SEL_NONE, 1'b0, 1'b0);
            expQ.push_back(EV_A);
            applyStimulus(COIN_NONE, SEL_A, 1'b0, 1'b0);
            applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b0);
            checks++;
            if (sold_out_A !== (i == 3)) begin
                failures++;
                $display("[TB] FAIL sold_out_A_vend%0d: got %b, expected %b", i, sold_out_A, (i == 3));
            end
        end
        applyStimulus(COIN_10, SEL_NONE, 1'b0, 1'b0);
        applyStimulus(COIN_NONE, SEL_A, 1'b0, 1'b0);
        applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b0);
        checks++; if ({busy, credit} !== {1'b0, 6'd10}) begin failures++; $display("[TB] FAIL empty_select: got busy %b credit %0d, expected 0 10", busy, credit); end
        applyStimulus(COIN_NONE, SEL_NONE, 1'b1, 1'b0);
        checks++; if (sold_out_A !== 1'b1) begin failures++; $display("[TB] FAIL refill_in_credit: got %b, expected 1", sold_out_A); end
        applyStimulus(COIN_NONE, SEL_CANCEL, 1'b0, 1'b0);
        applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b1);
        applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b1);
        applyStimulus(COIN_NONE, SEL_NONE, 1'b1, 1'b0);
        checks++; if ({sold_out_A, sold_out_B} !== 2'b00) begin failures++; $display("[TB] FAIL refill_idle: got %b, expected 00", {sold_out_A, sold_out_B}); end
        applyStimulus(COIN_10, SEL_NONE, 1'b0, 1'b0);
        expQ.push_back(EV_A);
        applyStimulus(COIN_NONE, SEL_A, 1'b0, 1'b0);
        applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b0);
        checks++; if (expQ.size() !== 0) begin failures++; $display("[TB] FAIL stock_pending: got %0d pending, expected 0", expQ.size()); end
    endtask

    task automatic test_reset_abort();
        applyStimulus(COIN_10, SEL_NONE, 1'b0, 1'b0);
        applyStimulus(COIN_NONE, SEL_CANCEL, 1'b0, 1'b0);
        checks++; if ({chg_req, credit} !== {1'b1, 6'd10}) begin failures++; $display("[TB] FAIL abort_pre: got req %b credit %0d, expected 1 10", chg_req, credit); end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++; if ({chg_req, busy, credit} !== {2'b00, 6'd0}) begin failures++; $display("[TB] FAIL abort_payout: got req %b busy %b credit %0d, expected 0 0 0", chg_req, busy, credit); end
        applyStimulus(COIN_10, SEL_NONE, 1'b0, 1'b0);
        applyStimulus(COIN_NONE, SEL_A, 1'b0, 1'b0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b0);
        checks++; if ({busy, credit} !== {1'b0, 6'd0}) begin failures++; $display("[TB] FAIL abort_vend: got busy %b credit %0d, expected 0 0", busy, credit); end
    endtask

    task automatic test_back_to_back();
        applyStimulus(COIN_10, SEL_NONE, 1'b0, 1'b0);
        applyStimulus(COIN_5, SEL_NONE, 1'b0, 1'b0);
        expQ.push_back(EV_B);
        applyStimulus(COIN_NONE, SEL_B, 1'b0, 1'b0);
        expQ.push_back(EV_REJ);
        applyStimulus(COIN_10, SEL_NONE, 1'b0, 1'b0);
        checks++; if ({busy, credit} !== {1'b0, 6'd0}) begin failures++; $display("[TB] FAIL b2b_first: got busy %b credit %0d, expected 0 0", busy, credit); end
        applyStimulus(COIN_10, SEL_NONE, 1'b0, 1'b0);
        expQ.push_back(EV_A);
        applyStimulus(COIN_NONE, SEL_A, 1'b0, 1'b0);
        applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b0);
        checks++; if (credit !== 6'd0) begin failures++; $display("[TB] FAIL b2b_second: got %0d, expected 0", credit); end
        checks++; if (expQ.size() !== 0) begin failures++; $display("[TB] FAIL b2b_pending: got %0d pending, expected 0", expQ.size()); end
    endtask

`ifdef VEND_TIMEOUT_EN
    task automatic test_timeout();
        applyStimulus(COIN_5, SEL_NONE, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b0);
        checks++; if (chg_req !== 1'b0) begin failures++; $display("[TB] FAIL timeout_early: got %b, expected 0", chg_req); end
        applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b0);
        checks++; if ({busy, chg_req} !== 2'b11) begin failures++; $display("[TB] FAIL timeout_fire: got busy/req %b, expected 11", {busy, chg_req}); end
        applyStimulus(COIN_NONE, SEL_NONE, 1'b0, 1'b1);
        checks++; if ({busy, chg_req, credit} !== {2'b00, 6'd0}) begin failures++; $display("[TB] FAIL timeout_refund: got busy %b req %b credit %0d, expected 0 0 0", busy, chg_req, credit); end
    endtask
`endif

    initial begin
        $display("[TB] vending_controller bench starting");
        test_reset();
        test_vend_exact();
        test_change();
        test_cap_and_cancel();
        test_insufficient();
        test_stock();
        test_reset_abort();
        test_back_to_back();
`ifdef VEND_TIMEOUT_EN
        test_timeout();
`endif
        cycle();
        checks++;
        if (expQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL final_pending: got %0d pending, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
